ahb_lite_sram: RTL and testbench
================================

# ahb_lite_sram

AHB-Lite slave memory holding SIZE_IN_BYTES bytes of zero-initialised storage, with programmable wait states and a two-cycle ERROR response. It sits directly downstream of the AHB master bus-functional model and is the target of its single and burst read/write memory tests. Byte, halfword and word accesses use little-endian byte lanes on a 32-bit data bus.

## Interface
- BASE_ADDR, 32'h0000_0000: first byte address decoded by this slave.
- SIZE_IN_BYTES, 32'h100: storage depth; must be a multiple of 4 and no larger than 64 KB.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in each NONSEQ/SEQ data phase; legal range 0..15.
- HCLK  in  1  bus clock; every register samples on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size: 000 byte, 001 halfword, 010 word.
- HBURST  in  3  burst type; accepted and ignored, because every beat carries its own address.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; qualifies address-phase sampling.
- HREADYOUT  out  1  slave ready; low extends the data phase.
- HRDATA  out  32  read data.
- HRESP  out  2  00 OKAY, 01 ERROR.

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge.
  - On accept, register the offset (HADDR-BASE_ADDR), HWRITE and HSIZE into the data-phase registers.
- If HSEL & HREADY are 1 and HTRANS is IDLE or BUSY, the next data phase is zero-wait OKAY with no memory access.
- An accepted transfer is an error when any of these holds:
  - offset ≥ SIZE_IN_BYTES;
  - HSIZE > 010;
  - HSIZE=001 and HADDR[0]=1;
  - HSIZE=010 and HADDR[1:0]≠00.
- State machine:
  - IDLE: no data phase pending. An OK transfer goes to WAIT if WAIT_STATES>0, else to ACCESS. An error transfer goes to ERR1.
  - WAIT: a down-counter loaded with WAIT_STATES-1 decrements each cycle. Go to ACCESS when it reaches 0.
  - ACCESS: final data-phase cycle. A new accepted transfer is evaluated here exactly as in IDLE; otherwise go to IDLE.
  - ERR1 goes to ERR2 on the next edge. ERR2 evaluates a new address phase exactly as in IDLE.
- Writes commit at the rising edge that ends ACCESS.
  - Byte enables are decoded from the registered offset[1:0] and HSIZE.
  - Only enabled lanes of HWDATA are written; the other bytes are unchanged.
- Reads: in ACCESS, HRDATA is the full 32-bit word at offset[..:2].
  - All four lanes are driven; the master extracts the lanes it needs.
- Read-after-write to the same word must return the new data.
  - This holds because the write commits on the edge that opens the read's data phase, and the read is combinational from the array.
- Error transfers never modify memory. During ERR1/ERR2, HRDATA = 0.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, state=IDLE, wait counter=0.
- Memory contents are zero only at time 0; HRESET does not clear them.
- Reset asserted mid-transfer: return to IDLE immediately; any pending write is discarded.
- Outputs by state:
  - IDLE: HREADYOUT=1, HRESP=00, HRDATA=0.
  - WAIT: HREADYOUT=0, HRESP=00.
  - ACCESS: HREADYOUT=1, HRESP=00, HRDATA = read word for a read, 0 for a write.
  - ERR1: HREADYOUT=0, HRESP=01. ERR2: HREADYOUT=1, HRESP=01.
- Latency per transfer is WAIT_STATES+1 data-phase cycles. Back-to-back pipelined bursts with WAIT_STATES=0 sustain one beat per cycle.
- When HSEL=0 or HREADY=0 at the end of ACCESS or ERR2, the next state is IDLE.

## Test plan
- Word access, WAIT_STATES=0: write 0xDEADBEEF @0x10, then read @0x10 → HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=00.
- Byte lanes: write word 0x11223344 @0x20, then byte 0xAA at 0x21 (HWDATA=0x0000AA00), then halfword 0xBBBB at 0x22 (HWDATA=0xBBBB0000); word read @0x20 → 0xBBBBAA44.
- INCR4 write burst 0x1,0x2,0x3,0x4 @0x40 immediately followed by an INCR4 read @0x40, WAIT_STATES=0 → reads return 1,2,3,4 on consecutive cycles with no stall.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, then high with data; HRDATA=0 during the wait cycles.
- Errors, each followed by a read of the target word showing it unchanged:
  - write @0x100 (out of range) → ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01);
  - word write @0x13 (misaligned) → same ERR1/ERR2 response;
  - HSIZE=011 → same ERR1/ERR2 response.
- Assert HRESET during the second wait cycle of a write with WAIT_STATES=3 → HREADYOUT=1 and HRESP=00 immediately, and the target word keeps its old value.

Source files
------------

// File: rtl/ahb_lite_sram.sv
// AHB-Lite slave SRAM: byte/halfword/word little-endian access on a 32-bit bus,
// programmable wait states per data phase and a two-cycle ERROR response.
module ahb_lite_sram #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [31:0] SIZE_IN_BYTES = 32'h100,
    parameter int          WAIT_STATES   = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);

    localparam int DEPTH = int'(SIZE_IN_BYTES >> 2);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW    = AW + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_ERR1   = 3'd3;
    localparam logic [2:0] S_ERR2   = 3'd4;

    localparam logic [3:0] W_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [3:0]    r_cnt;
    logic [OW-1:0] r_off;
    logic          r_write;
    logic [1:0]    r_size;

    // Storage starts at zero; reset deliberately leaves it alone.
    logic [31:0]   r_mem [0:DEPTH-1] = '{default: 32'h0};

    logic [31:0]   w_off;
    logic          w_accept;
    logic          w_err;
    logic          w_eval;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    // HBURST is ignored: every beat carries its own address.
    assign w_unused = ^{HTRANS[0], HBURST};

    assign w_off    = HADDR - BASE_ADDR;
    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_err    = (w_off >= SIZE_IN_BYTES)
                    | (HSIZE > 3'b010)
                    | ((HSIZE == 3'b001) & HADDR[0])
                    | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));
    // A new address phase can only be taken in a state that drives HREADYOUT high.
    assign w_eval   = (r_state == S_IDLE) | (r_state == S_ACCESS) | (r_state == S_ERR2);
    assign w_idx    = r_off[OW-1:2];

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ACCESS, S_ERR2: begin
                if (!w_accept)             w_next = S_IDLE;
                else if (w_err)            w_next = S_ERR1;
                else if (WAIT_STATES > 0)  w_next = S_WAIT;
                else                       w_next = S_ACCESS;
            end
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_ACCESS;
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    // State, wait counter and data-phase registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_off   <= '0;
            r_write <= 1'b0;
            r_size  <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_eval && w_accept) begin
                r_off   <= w_off[OW-1:0];
                r_write <= HWRITE;
                r_size  <= HSIZE[1:0];
            end
            if (w_eval && w_accept && !w_err)
                r_cnt <= W_LOAD;
            else if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    // Byte-lane enables from the registered offset and size
    always_comb begin
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_off[1:0];
            2'd1:    w_be = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Write commits on the edge that closes ACCESS; an async reset clears the
    // state first, so a pending write is dropped.
    always_ff @(posedge HCLK) begin
        if (r_state == S_ACCESS && r_write) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    // Outputs decoded from state; read data is combinational from the array
    always_comb begin
        HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
        HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
        HRDATA    = (r_state == S_ACCESS && !r_write) ? r_mem[w_idx] : 32'h0;
    end

endmodule

// File: tb/tb_ahb_lite_sram.sv
// Bench for ahb_lite_sram: two instances (0 and 3 wait states), a pipelined
// driver, a byte-array reference model and a queue-based response monitor.
module tb_ahb_lite_sram;

    localparam int SIZE = 256;
    localparam int WS0  = 0;
    localparam int WS1  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, hsel, hwrite, hrdyo;
    logic [1:0][31:0] haddr, hwdata, hrdata;
    logic [1:0][1:0]  htrans, hresp;
    logic [1:0][2:0]  hsize, hburst;

    ahb_lite_sram #(.BASE_ADDR(32'h0), .SIZE_IN_BYTES(32'h100), .WAIT_STATES(WS0)) u_ws0 (
        .HCLK(clk), .HRESET(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hrdyo[0]), .HREADYOUT(hrdyo[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]));

    ahb_lite_sram #(.BASE_ADDR(32'h0), .SIZE_IN_BYTES(32'h100), .WAIT_STATES(WS1)) u_ws3 (
        .HCLK(clk), .HRESET(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hrdyo[1]), .HREADYOUT(hrdyo[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]));

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } beat_t;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    beat_t        bq[$];
    exp_t         q0[$];
    exp_t         q1[$];
    byte unsigned model [2][SIZE];

    int checks   = 0;
    int failures = 0;

    bit pend  [2];
    int waits [2];
    int elow  [2];

    function automatic int ws(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: decides OKAY/ERROR from the address rules, applies
    // writes byte by byte, and predicts read words from the byte array.
    task automatic model_beat(input int k, input beat_t b);
        exp_t e;
        bit   misal;
        int   nb;
        int   base;
        int   a;
        misal  = (b.size == 3'd1 && b.addr[0]) || (b.size == 3'd2 && b.addr[1:0] != 2'b00);
        e.err  = (b.addr >= 32'(SIZE)) || (b.size > 3'd2) || misal;
        e.rd   = !b.wr;
        e.data = 32'h0;
        if (!e.err) begin
            nb   = 1 << b.size;
            base = int'(b.addr) & ~3;
            if (b.wr) begin
                for (int i = 0; i < nb; i++) begin
                    a = int'(b.addr) + i;
                    model[k][a] = b.wdata[8*(a%4) +: 8];
                end
            end else begin
                e.data = {model[k][base+3], model[k][base+2], model[k][base+1], model[k][base]};
            end
        end
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic add(input logic [31:0] a, input bit w, input logic [2:0] s,
                       input logic [31:0] d, input logic [1:0] t);
        beat_t b;
        b.addr = a; b.wr = w; b.size = s; b.wdata = d; b.trans = t;
        bq.push_back(b);
    endtask

    // Pipelined AHB driver: address of beat i overlaps data of beat i-1;
    // each address phase is held until HREADY is seen high at an edge.
    task automatic run(input int k);
        int n;
        bit r;
        int guard;
        n = bq.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel[k]   = 1'b1;
                haddr[k]  = bq[i].addr;
                htrans[k] = bq[i].trans;
                hwrite[k] = bq[i].wr;
                hsize[k]  = bq[i].size;
                hburst[k] = 3'($urandom_range(0, 7));
                if (bq[i].trans[1]) model_beat(k, bq[i]);
            end else begin
                hsel[k]   = 1'b0;
                htrans[k] = 2'b00;
                hwrite[k] = 1'b0;
                haddr[k]  = $urandom;
            end
            hwdata[k] = $urandom;
            if (i > 0) begin
                if (bq[i-1].wr) hwdata[k] = bq[i-1].wdata;
            end
            guard = 0;
            do begin
                @(negedge clk);
                r = hrdyo[k];
                @(posedge clk);
                #1;
                guard++;
            end while (!r && guard < 40);
            if (!r) begin
                checks++;
                failures++;
                $display("FAIL u%0d_hready_timeout: actual=stuck_low expected=high_within_40", k);
            end
        end
        bq.delete();
    endtask

    task automatic rand_beats(input int n);
        logic [31:0] a;
        logic [2:0]  s;
        logic [1:0]  t;
        int          sel;
        for (int i = 0; i < n; i++) begin
            s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(SIZE, SIZE + 31));
            else                          a = 32'($urandom_range(0, SIZE - 1));
            if (s <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            sel = $urandom_range(0, 7);
            t   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel < 5) ? 2'b10 : 2'b11;
            add(a, 1'($urandom_range(0, 1)), s, $urandom, t);
        end
    endtask

    // Monitor: tracks data phases from the bus and checks each completion
    // against the next queued expectation.
    task automatic mon_step(input int k);
        exp_t e;
        int   qs;
        if (rst[k]) begin
            pend[k] = 1'b0; waits[k] = 0; elow[k] = 0;
            return;
        end
        if (pend[k]) begin
            if (!hrdyo[k]) begin
                waits[k]++;
                if (hresp[k] == 2'b01) elow[k]++;
                chk($sformatf("u%0d_stall_rdata", k), hrdata[k], 32'h0);
            end else begin
                qs = (k == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL u%0d_unexpected_phase: actual=completion expected=none", k);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (e.err) begin
                        chk($sformatf("u%0d_err_resp", k), 32'(hresp[k]), 32'h1);
                        chk($sformatf("u%0d_err1_cycles", k), 32'(waits[k]), 32'd1);
                        chk($sformatf("u%0d_err1_resp", k), 32'(elow[k]), 32'd1);
                        chk($sformatf("u%0d_err_rdata", k), hrdata[k], 32'h0);
                    end else begin
                        chk($sformatf("u%0d_ok_resp", k), 32'(hresp[k]), 32'h0);
                        chk($sformatf("u%0d_wait_cycles", k), 32'(waits[k]), 32'(ws(k)));
                        chk($sformatf("u%0d_wait_resp", k), 32'(elow[k]), 32'd0);
                        chk($sformatf("u%0d_rdata", k), hrdata[k], e.rd ? e.data : 32'h0);
                    end
                end
                waits[k] = 0;
                elow[k]  = 0;
            end
        end else begin
            chk($sformatf("u%0d_idle_ready", k), 32'(hrdyo[k]), 32'h1);
            chk($sformatf("u%0d_idle_resp", k), 32'(hresp[k]), 32'h0);
            chk($sformatf("u%0d_idle_rdata", k), hrdata[k], 32'h0);
        end
        if (hrdyo[k]) pend[k] = hsel[k] && htrans[k][1];
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) mon_step(k);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; hsel = '0; hwrite = '0; haddr = '0; hwdata = '0;
        htrans = '0; hsize = '0; hburst = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_reset_ready", k), 32'(hrdyo[k]), 32'h1);
            chk($sformatf("u%0d_reset_resp", k), 32'(hresp[k]), 32'h0);
            chk($sformatf("u%0d_reset_rdata", k), hrdata[k], 32'h0);
        end
        rst = 2'b00;
        @(posedge clk);
        #1;

        // Zero-wait word write/read
        add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
        add(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
        // Byte lanes merge into 0xBBBBAA44
        add(32'h20, 1'b1, 3'd2, 32'h11223344, 2'b10);
        add(32'h21, 1'b1, 3'd0, 32'h0000AA00, 2'b10);
        add(32'h22, 1'b1, 3'd1, 32'hBBBB0000, 2'b10);
        add(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
        // INCR4 write then INCR4 read, back to back
        for (int i = 0; i < 4; i++)
            add(32'h40 + 32'(4*i), 1'b1, 3'd2, 32'(i + 1), (i == 0) ? 2'b10 : 2'b11);
        for (int i = 0; i < 4; i++)
            add(32'h40 + 32'(4*i), 1'b0, 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11);
        // Error cases, each followed by a read showing memory unchanged
        add(32'h100, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b10);
        add(32'hFC, 1'b0, 3'd2, 32'h0, 2'b10);
        add(32'h13, 1'b1, 3'd2, 32'h55555555, 2'b10);
        add(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
        add(32'h20, 1'b1, 3'd3, 32'h66666666, 2'b10);
        add(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
        run(0);

        // Three-wait instance: write, read, then reset mid-write
        add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
        add(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
        add(32'h30, 1'b1, 3'd2, 32'h12345678, 2'b10);
        add(32'h30, 1'b0, 3'd2, 32'h0, 2'b10);
        run(1);

        hsel[1] = 1'b1; haddr[1] = 32'h30; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2;
        @(negedge clk);
        @(posedge clk);
        #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwrite[1] = 1'b0; hwdata[1] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        chk("u1_midreset_ready", 32'(hrdyo[1]), 32'h1);
        chk("u1_midreset_resp", 32'(hresp[1]), 32'h0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;
        add(32'h30, 1'b0, 3'd2, 32'h0, 2'b10);
        run(1);

        // Randomised traffic on both instances
        for (int r = 0; r < 4; r++) begin
            rand_beats(60);
            run(0);
            rand_beats(40);
            run(1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("u0_queue_drained", 32'(q0.size()), 32'd0);
        chk("u1_queue_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
